cfg_responder: RTL and testbench

- Target end of the configuration link driven by the configuration controller.
- Deserialises write frames into a local register file, serialises read-back data for the controller's verify pass, and raises flag_cs once a clean full configuration is held.
- Sits on the device side of the link. Shares cs, bit-strobe and serial-data lines with the controller and wdata path.

---
 rtl/cfg_responder_if.sv | 27 ++
 rtl/cfg_responder.sv | 205 ++++++++++++++++++++
 tb/tb_cfg_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_responder_if.sv
// Serial configuration link between the configuration controller and the
// device-side responder.
//   cs_i   : chip select, active-high, frames one 16-bit transfer
//   bit_en : one-clk bit strobe, one frame bit per strobe
//   sdi    : serial data towards the responder, MSB first
//   sdo    : serial read-back data towards the controller, MSB first
// master = controller side, slave = responder side.
interface cfg_responder_if;
    logic cs_i;
    logic bit_en;
    logic sdi;
    logic sdo;

    modport master (
        output cs_i,
        output bit_en,
        output sdi,
        input  sdo
    );

    modport slave (
        input  cs_i,
        input  bit_en,
        input  sdi,
        output sdo
    );
endinterface

// File: rtl/cfg_responder.sv
// Device-side end of the serial configuration link.
// Deserialises 16-bit frames (RW, 4-bit addr, 3 pad bits, 8 data bits, MSB
// first), commits writes into a local register file, shifts register
// contents back out on reads, and reports when every register has been
// written with no aborted frame in between.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   link       : serial link (cs_i, bit_en, sdi in; sdo out)
//   cfg_regs   : flat register view, reg n at [8n+7:8n]
//   flag_cs    : registered "full clean configuration held" flag
//   frame_err  : sticky, set when a frame is cut short by deselect
//   busy       : a frame is in progress (state not IDLE)
module cfg_responder #(
    parameter int NUM_REGS = 12,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    cfg_responder_if.slave             link,
    output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
    output logic                       flag_cs,
    output logic                       frame_err,
    output logic                       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          bit_cnt_reg, bit_cnt_next;
    // Only the last seven samples are ever needed: together with the live
    // sdi bit they form the header byte or the data byte.
    logic [6:0]          shift_reg, shift_next;
    logic [7:0]          tx_reg, tx_next;
    logic [3:0]          addr_reg, addr_next;
    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] written_mask_reg;
    logic                frame_err_reg;
    logic                flag_cs_reg;

    logic                sample;
    logic                abort;
    logic                commit;
    logic                clr_en;
    logic [7:0]          wdata;
    logic [DATA_W-1:0]   rd_data;
    logic [NUM_REGS-1:0] wr_sel;

    // Deselect always wins over a coincident strobe.
    assign sample = link.cs_i & link.bit_en;
    assign wdata  = {shift_reg, link.sdi};

    // Read-back mux driven by the address bits of the header as it completes;
    // unimplemented addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_reg[5:2] == 4'(i)) begin
                rd_data = reg_q[i];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        addr_next    = addr_reg;
        abort        = 1'b0;
        commit       = 1'b0;
        clr_en       = 1'b0;

        case (state_reg)
            IDLE: begin
                bit_cnt_next = 4'd0;
                if (sample) begin
                    shift_next   = {shift_reg[5:0], link.sdi};
                    bit_cnt_next = 4'd1;
                    state_next   = HDR;
                end
            end
            HDR: begin
                if (!link.cs_i) begin
                    abort = 1'b1;
                end else if (link.bit_en) begin
                    shift_next   = {shift_reg[5:0], link.sdi};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) begin
                        // shift_reg[6] = RW, [5:2] = addr, [1:0] + sdi = pad
                        addr_next = shift_reg[5:2];
                        if (shift_reg[6]) begin
                            state_next = WDATA;
                        end else begin
                            state_next = RDATA;
                            tx_next    = 8'(rd_data);
                        end
                    end
                end
            end
            WDATA: begin
                if (!link.cs_i) begin
                    abort = 1'b1;
                end else if (link.bit_en) begin
                    shift_next   = {shift_reg[5:0], link.sdi};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd15) begin
                        state_next = DONE;
                        commit     = 1'b1;
                        // Address 15 with data bit 0 set restarts the
                        // configuration bookkeeping.
                        clr_en     = (addr_reg == 4'hF) & link.sdi;
                    end
                end
            end
            RDATA: begin
                if (!link.cs_i) begin
                    abort = 1'b1;
                end else if (link.bit_en) begin
                    tx_next      = {tx_reg[6:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd15) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Surplus strobes after a complete frame are ignored.
                if (!link.cs_i) begin
                    state_next   = IDLE;
                    bit_cnt_next = 4'd0;
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = 4'd0;
            end
        endcase

        if (abort) begin
            state_next   = IDLE;
            bit_cnt_next = 4'd0;
        end
    end

    // Per-register write decode; wr_sel stays zero for addresses outside the
    // implemented range, so those writes fall away silently.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_sel[gi] = commit & (addr_reg == 4'(gi));
            assign cfg_regs[gi*DATA_W +: DATA_W] = reg_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= 4'd0;
            shift_reg        <= '0;
            tx_reg           <= '0;
            addr_reg         <= '0;
            written_mask_reg <= '0;
            frame_err_reg    <= 1'b0;
            flag_cs_reg      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            addr_reg    <= addr_next;

            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    reg_q[i]            <= DATA_W'(wdata);
                    written_mask_reg[i] <= 1'b1;
                end
            end

            if (clr_en) begin
                written_mask_reg <= '0;
                frame_err_reg    <= 1'b0;
            end else if (abort) begin
                frame_err_reg <= 1'b1;
            end

            // Built from the pre-edge mask/error, so the flag trails the
            // completing write or the abort by one clock.
            flag_cs_reg <= (&written_mask_reg) & ~frame_err_reg;
        end
    end

    assign link.sdo  = (state_reg == RDATA) & tx_reg[7];
    assign flag_cs   = flag_cs_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_cfg_responder.sv
module tb_cfg_responder;

    localparam int NUM_REGS = 12;
    localparam int S_SDO  = 100;
    localparam int S_FLAG = 101;
    localparam int S_FERR = 102;
    localparam int S_BUSY = 103;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REGS*8-1:0] cfg_regs;
    logic                  flag_cs;
    logic                  frame_err;
    logic                  busy;

    cfg_responder_if link ();

    cfg_responder #(.NUM_REGS(NUM_REGS), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .link      (link),
        .cfg_regs  (cfg_regs),
        .flag_cs   (flag_cs),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model [NUM_REGS];

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            S_SDO:   return {7'd0, link.sdo};
            S_FLAG:  return {7'd0, flag_cs};
            S_FERR:  return {7'd0, frame_err};
            S_BUSY:  return {7'd0, busy};
            default: return cfg_regs[sel*8 +: 8];
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = sb.pop_front();
            act = observe(e.sel);
            total++;
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got=%h expected=%h", e.name, act, e.val);
            end else begin
                $display("check %s: got=%h expected=%h ok", e.name, act, e.val);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk_frame(input logic rw, input logic [3:0] addr,
                                             input logic [7:0] data);
        return {rw, addr, 3'b000, data};
    endfunction

    task automatic send_frame(input logic [15:0] f, input int nbits,
                              input bit is_read, input logic [7:0] rd_exp);
        for (int i = 0; i < nbits; i++) begin
            link.cs_i   = 1'b1;
            link.bit_en = 1'b1;
            link.sdi    = f[15-i];
            if (is_read) begin
                if (i < 8) expect_val($sformatf("sdo_hdr%0d", i), S_SDO, 8'h00);
                else       expect_val($sformatf("sdo_bit%0d", 15 - i), S_SDO,
                                      {7'd0, rd_exp[15-i]});
            end
            tick();
            link.bit_en = 1'b0;
            if (i != nbits - 1) tick();
        end
    endtask

    task automatic deselect();
        link.cs_i   = 1'b0;
        link.bit_en = 1'b0;
        tick();
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [7:0] data);
        send_frame(mk_frame(1'b1, addr, data), 16, 1'b0, 8'h00);
        if (int'(addr) < NUM_REGS) model[addr] = data;
        expect_val($sformatf("reg%0d_after_wr", addr), int'(addr) < NUM_REGS ? int'(addr) : 0,
                   int'(addr) < NUM_REGS ? data : model[0]);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            expect_val($sformatf("%s_reg%0d", tag, i), i, model[i]);
        end
    endtask

    initial begin
        link.cs_i   = 1'b0;
        link.bit_en = 1'b0;
        link.sdi    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;

        tick();
        total++;
        if (busy !== 1'b0 || flag_cs !== 1'b0) begin
            bad++;
            $display("FAIL rst_direct: got=%b%b expected=00", busy, flag_cs);
        end else begin
            $display("check rst_direct: got=%b%b expected=00 ok", busy, flag_cs);
        end
        expect_val("rst_busy", S_BUSY, 8'h00);
        expect_val("rst_flag", S_FLAG, 8'h00);
        expect_val("rst_ferr", S_FERR, 8'h00);
        expect_val("rst_sdo",  S_SDO,  8'h00);
        expect_val("rst_reg3", 3, 8'h00);
        rst = 1'b0;
        tick();

        write_reg(4'd3, 8'hA5);
        total++;
        if (cfg_regs[31:24] !== 8'hA5) begin
            bad++;
            $display("FAIL wr3_direct: got=%h expected=a5", cfg_regs[31:24]);
        end else begin
            $display("check wr3_direct: got=%h expected=a5 ok", cfg_regs[31:24]);
        end
        expect_val("wr3_busy_done", S_BUSY, 8'h01);
        expect_val("wr3_flag", S_FLAG, 8'h00);
        deselect();
        expect_val("wr3_busy_idle", S_BUSY, 8'h00);
        tick();
        expect_val("wr3_flag_later", S_FLAG, 8'h00);

        for (int a = 0; a < NUM_REGS; a++) begin
            write_reg(4'(a), 8'(a * 8'h11));
            if (a == NUM_REGS - 1) begin
                expect_val("fill_flag_commit_edge", S_FLAG, 8'h00);
                tick();
                expect_val("fill_flag_next_clk", S_FLAG, 8'h01);
                total++;
                if (flag_cs !== 1'b1) begin
                    bad++;
                    $display("FAIL fill_flag_direct: got=%b expected=1", flag_cs);
                end else begin
                    $display("check fill_flag_direct: got=%b expected=1 ok", flag_cs);
                end
            end
            deselect();
        end

        send_frame(mk_frame(1'b0, 4'd5, 8'h00), 16, 1'b1, 8'h55);
        deselect();
        expect_val("rd5_busy", S_BUSY, 8'h00);
        expect_val("rd5_flag", S_FLAG, 8'h01);

        send_frame(mk_frame(1'b1, 4'd2, 8'hEE), 10, 1'b0, 8'h00);
        deselect();
        total++;
        if (frame_err !== 1'b1) begin
            bad++;
            $display("FAIL abort_ferr_direct: got=%b expected=1", frame_err);
        end else begin
            $display("check abort_ferr_direct: got=%b expected=1 ok", frame_err);
        end
        expect_val("abort_ferr", S_FERR, 8'h01);
        expect_val("abort_flag_same", S_FLAG, 8'h01);
        expect_val("abort_busy", S_BUSY, 8'h00);
        expect_val("abort_reg2", 2, 8'h22);
        tick();
        expect_val("abort_flag_next", S_FLAG, 8'h00);

        send_frame(mk_frame(1'b1, 4'hF, 8'h01), 16, 1'b0, 8'h00);
        expect_val("clr_ferr", S_FERR, 8'h00);
        expect_val("clr_flag", S_FLAG, 8'h00);
        deselect();
        check_all_regs("clr");

        for (int a = 0; a < NUM_REGS; a++) begin
            write_reg(4'(a), 8'(a) + 8'h40);
            if (a == NUM_REGS - 2) begin
                tick();
                expect_val("rewr_flag_partial", S_FLAG, 8'h00);
            end
            if (a == NUM_REGS - 1) begin
                expect_val("rewr_flag_commit_edge", S_FLAG, 8'h00);
                tick();
                expect_val("rewr_flag_next_clk", S_FLAG, 8'h01);
            end
            deselect();
        end

        send_frame(mk_frame(1'b0, 4'd13, 8'h00), 16, 1'b1, 8'h00);
        deselect();
        send_frame(mk_frame(1'b1, 4'd13, 8'hFF), 16, 1'b0, 8'h00);
        deselect();
        check_all_regs("wr13");
        expect_val("wr13_flag", S_FLAG, 8'h01);
        expect_val("wr13_ferr", S_FERR, 8'h00);

        link.cs_i   = 1'b0;
        link.bit_en = 1'b1;
        link.sdi    = 1'b1;
        tick();
        link.bit_en = 1'b0;
        expect_val("desel_strobe_busy", S_BUSY, 8'h00);
        tick();
        expect_val("desel_strobe_busy2", S_BUSY, 8'h00);
        expect_val("desel_strobe_ferr", S_FERR, 8'h00);

        send_frame(mk_frame(1'b1, 4'd4, 8'h99), 11, 1'b0, 8'h00);
        link.cs_i   = 1'b1;
        link.bit_en = 1'b1;
        link.sdi    = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mrst_busy_direct: got=%b expected=0", busy);
        end else begin
            $display("check mrst_busy_direct: got=%b expected=0 ok", busy);
        end
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        expect_val("mrst_busy", S_BUSY, 8'h00);
        expect_val("mrst_flag", S_FLAG, 8'h00);
        expect_val("mrst_ferr", S_FERR, 8'h00);
        expect_val("mrst_sdo",  S_SDO,  8'h00);
        check_all_regs("mrst");
        tick();
        link.cs_i   = 1'b0;
        link.bit_en = 1'b0;
        rst = 1'b0;
        tick();

        write_reg(4'd7, 8'h3C);
        total++;
        if (cfg_regs[63:56] !== 8'h3C) begin
            bad++;
            $display("FAIL post_rst_reg7_direct: got=%h expected=3c", cfg_regs[63:56]);
        end else begin
            $display("check post_rst_reg7_direct: got=%h expected=3c ok", cfg_regs[63:56]);
        end
        expect_val("post_rst_reg4", 4, 8'h00);
        expect_val("post_rst_flag", S_FLAG, 8'h00);
        expect_val("post_rst_ferr", S_FERR, 8'h00);
        deselect();
        send_frame(mk_frame(1'b0, 4'd7, 8'h00), 16, 1'b1, 8'h3C);
        deselect();
        expect_val("post_rst_busy", S_BUSY, 8'h00);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
